// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with active-low request/grant and a one-cycle
// turnaround (SWITCH) on every ownership change.
// Optional tenure limit with lock override: define BUS_ARB_TIMEOUT_EN.
// Outputs are decoded from registers only.

module bus_arbiter_rr #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_HOLD    = 16,
    localparam int unsigned OWNER_W    = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req_,
    input  logic [NUM_MASTERS-1:0] m_lock_,
    output logic [NUM_MASTERS-1:0] m_grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   preempt
);

    typedef enum logic [0:0] {StGrant, StSwitch} state_e;

    state_e               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   next_owner_q, next_owner_d;
    logic                 preempt_q, preempt_d;

    logic [OWNER_W-1:0]   owner_eff;
    logic                 owner_req;
    logic                 found;
    logic [OWNER_W-1:0]   winner;
    logic [OWNER_W-1:0]   cand;
    logic                 expired;

    // An out-of-range owner (non-power-of-two builds) decodes as parked master 0.
    assign owner_eff = (32'(owner_q) < NUM_MASTERS) ? owner_q : '0;
    assign owner_req = ~m_req_[owner_eff];

    // First requester among the other masters, scanning owner+1, owner+2, ...
    always_comb begin
        found  = 1'b0;
        winner = owner_eff;
        cand   = owner_eff;
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            cand = OWNER_W'((32'(owner_eff) + i) % NUM_MASTERS);
            if (!found && !m_req_[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Tenure expiry: limit reached, owner still wants the bus, not locked, and
    // someone else is waiting.
    assign expired = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) && owner_req &&
                     m_lock_[owner_eff] && found;
`else
    localparam int unsigned unused_max_hold = MAX_HOLD;

    logic unused_lock;
    assign unused_lock = ^m_lock_;
    assign expired     = 1'b0;
`endif

    // Next-state: keep owner, park, or start a handover through SWITCH.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        next_owner_d = next_owner_q;
        preempt_d    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_cnt_d   = hold_cnt_q;
`endif
        unique case (state_q)
            StGrant: begin
                if (owner_req && !expired) begin
`ifdef BUS_ARB_TIMEOUT_EN
                    if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end else if (!found) begin
                    // Nobody else wants the bus: stay parked on the owner.
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    next_owner_d = winner;
                    state_d      = StSwitch;
                    preempt_d    = expired;
                end
            end
            StSwitch: begin
                // Commit regardless of the new owner's current request.
                owner_d = next_owner_q;
                state_d = StGrant;
`ifdef BUS_ARB_TIMEOUT_EN
                hold_cnt_d = '0;
`endif
            end
            default: begin
                state_d = StGrant;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StGrant;
            owner_q      <= '0;
            next_owner_q <= '0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            next_owner_q <= next_owner_d;
            preempt_q    <= preempt_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Tenure counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // Grant decode: one low bit in GRANT, all high during turnaround.
    always_comb begin
        m_grnt_ = '1;
        if (state_q == StGrant) begin
            m_grnt_[owner_eff] = 1'b0;
        end
    end

    assign owner   = owner_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (4 masters, MAX_HOLD = 4).

module tb_bus_arbiter_rr;

    localparam int unsigned NM = 4;
    localparam int unsigned MH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] m_req_;
    logic [3:0] m_lock_;
    logic [3:0] m_grnt_;
    logic [1:0] owner;
    logic       preempt;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_MASTERS (NM),
        .MAX_HOLD    (MH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req_  (m_req_),
        .m_lock_ (m_lock_),
        .m_grnt_ (m_grnt_),
        .owner   (owner),
        .preempt (preempt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, in terms of the bus behaviour rather than RTL.
    int mdl_owner  = 0;
    int mdl_target = 0;
    int mdl_held   = 0;
    bit mdl_sw     = 1'b0;
    bit mdl_pre    = 1'b0;

    function automatic int first_other(int own, logic [3:0] req);
        for (int k = 1; k < NM; k++) begin
            int j;
            j = (own + k) % NM;
            if (req[j] == 1'b0) return j;
        end
        return -1;
    endfunction

    task automatic mdl_update();
        if (reset) begin
            mdl_owner = 0; mdl_target = 0; mdl_held = 0; mdl_sw = 0; mdl_pre = 0;
        end else if (mdl_sw) begin
            mdl_owner = mdl_target; mdl_sw = 0; mdl_held = 0; mdl_pre = 0;
        end else begin
            bit own_req;
            bit exp;
            int w;
            w       = first_other(mdl_owner, m_req_);
            own_req = (m_req_[mdl_owner] == 1'b0);
            exp     = TimeoutEn && (mdl_held == MH - 1) && own_req &&
                      m_lock_[mdl_owner] && (w >= 0);
            mdl_pre = 0;
            if (own_req && !exp) begin
                if (mdl_held < MH) mdl_held++;
            end else if (w < 0) begin
                mdl_held = 0;
            end else begin
                mdl_target = w; mdl_sw = 1; mdl_pre = exp;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [3:0] exp_grnt;
        @(posedge clk);
        mdl_update();
        #1;
        exp_grnt = mdl_sw ? 4'hF : ~(4'b0001 << mdl_owner);
        check("grant", 32'(m_grnt_), 32'(exp_grnt));
        check("owner", 32'(owner), 32'(mdl_owner));
        check("preempt", 32'(preempt), 32'(mdl_pre));
    endtask

    initial begin
        int order[$];
        int last;
        int run;
        int cnt;
        int bad;

        // Reset and idle parking on master 0.
        reset = 1'b1; m_req_ = 4'hF; m_lock_ = 4'hF;
        step(); step();
        check("rst_grant", 32'(m_grnt_), 32'h0000_000E);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_preempt", 32'(preempt), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("idle_grant", 32'(m_grnt_), 32'h0000_000E);

        // Handover 0 -> 1 with one turnaround cycle.
        m_req_ = 4'b1101;
        step();
        check("ho_switch", 32'(m_grnt_), 32'h0000_000F);
        step();
        check("ho_grant", 32'(m_grnt_), 32'h0000_000D);
        check("ho_owner", 32'(owner), 32'h1);

        // Rotation with everyone requesting; owner drops after two cycles.
        m_req_ = 4'b0000;
        last = 1; run = 0;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            step();
            if (mdl_sw) begin
                run = 0;
            end else begin
                run++;
                if (mdl_owner != last) begin
                    order.push_back(mdl_owner);
                    last = mdl_owner;
                end
            end
            m_req_ = (!mdl_sw && run >= 2) ? 4'(4'b0001 << mdl_owner) : 4'b0000;
        end
        check("rot_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size(); i++) begin
            check("rot_order", 32'(order[i]), 32'((i + 2) % NM));
        end

        // Tenure: masters 0 and 2 requesting steadily.
        reset = 1'b1; m_req_ = 4'hF; m_lock_ = 4'hF;
        step();
        reset = 1'b0; m_req_ = 4'b1010;
        cnt = 1;
        for (int i = 0; i < 110; i++) begin
            step();
            if (m_grnt_ == 4'b1110) cnt++;
            else break;
        end
        if (TimeoutEn) begin
            check("tenure_len", 32'(cnt), 32'd4);
            check("tenure_pre", 32'(preempt), 32'h1);
            step();
            check("tenure_grant", 32'(m_grnt_), 32'h0000_000B);
            check("tenure_owner", 32'(owner), 32'h2);

            // Locked owner is never preempted.
            reset = 1'b1; m_req_ = 4'hF; m_lock_ = 4'b1110;
            step();
            reset = 1'b0; m_req_ = 4'b1010;
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (m_grnt_ != 4'b1110 || preempt != 1'b0) bad++;
            end
            check("lock_hold", 32'(bad), 32'd0);
            m_lock_ = 4'hF;
        end else begin
            check("nolimit_len", 32'(cnt), 32'd111);
        end

        // Reset during a turnaround discards the pending owner.
        reset = 1'b1; m_req_ = 4'hF;
        step();
        reset = 1'b0; m_req_ = 4'b0111;
        step();
        check("rsw_switch", 32'(m_grnt_), 32'h0000_000F);
        reset = 1'b1;
        step();
        check("rsw_grant", 32'(m_grnt_), 32'h0000_000E);
        check("rsw_owner", 32'(owner), 32'h0);
        reset = 1'b0; m_req_ = 4'hF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m_grnt_[3] != 1'b1) bad++;
        end
        check("rsw_no_m3", 32'(bad), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            m_req_  = 4'($urandom);
            m_lock_ = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            reset   = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
